// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write scheduler.
// Holds the scheduler state encoding, the fixed AXI4 field values and the
// burst-size helper used by the scheduler and its address generator.
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_32B   = 3'b101;

    // One beat is one 256-bit word.
    localparam int unsigned WORD_BYTES = 32;

    // Bytes covered by one burst of burst_len words.
    function automatic int unsigned burst_bytes(input int unsigned burst_len);
        return burst_len * WORD_BYTES;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Write pointer for the DDR region: steps by one burst per advance pulse and
// wraps back to the region start when the next step would reach region end.
// Ports:
//   clk, rst_n  clock and async active-low reset (pointer returns to BASE_ADDR)
//   advance     one-cycle pulse, move to the next burst slot
//   addr        current burst start address
module burst_addr_gen
#(
    parameter int unsigned              ADDR_WIDTH   = 32,
    parameter int unsigned              STEP_BYTES   = 512,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0]    REGION_BYTES = ADDR_WIDTH'(32'h0010_0000)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(STEP_BYTES);
    localparam logic [ADDR_WIDTH-1:0] END_ADR = BASE_ADDR + REGION_BYTES;

    logic [ADDR_WIDTH-1:0] next_addr;

    // Region size is a multiple of the step, so equality is the exact wrap point.
    always_comb begin
        next_addr = addr + STEP;
        if (next_addr == END_ADR) begin
            next_addr = BASE_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= BASE_ADDR;
        end else if (advance) begin
            addr <= next_addr;
        end
    end

endmodule

// File: rtl/ddr_write_scheduler.sv
// Drains full bursts of packed 256-bit words from the word FIFO into DDR as
// AXI4 INCR write bursts, one outstanding transaction at a time.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                allow new bursts to start (running burst always completes)
//   fifo_empty/count/dout FWFT word FIFO read side; fifo_rd_en pops one word
//   m_aw*, m_w*, m_b*     AXI4 write address / data / response channels
//   busy                  scheduler not idle
//   wr_err                sticky, some burst returned a non-OKAY response
//   bursts_done           completed-burst counter (wraps)
module ddr_write_scheduler
    import ddr_wr_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH   = 256,
    parameter int unsigned              ADDR_WIDTH   = 32,
    parameter int unsigned              BURST_LEN    = 16,
    parameter int unsigned              CNT_WIDTH    = 10,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0]    REGION_BYTES = ADDR_WIDTH'(32'h0010_0000)
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [CNT_WIDTH-1:0]    fifo_count,
    input  logic [DATA_WIDTH-1:0]   fifo_dout,
    output logic                    fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    busy,
    output logic                    wr_err,
    output logic [31:0]             bursts_done
);

    localparam int unsigned          BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam int unsigned          STEP_BYTES = burst_bytes(BURST_LEN);

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic                aw_valid_q;
    logic                b_ready_q;
    logic                err_q;
    logic [31:0]         done_q;
    logic                start;
    logic                in_data;
    logic                advance;

    // Only whole bursts are ever issued.
    assign start   = enable && (32'(fifo_count) >= BURST_LEN);
    assign in_data = (state == ST_DATA);
    assign advance = b_ready_q && m_bvalid;

    // W channel follows the FIFO head directly; an empty FIFO simply stalls the burst.
    assign m_wvalid   = in_data && !fifo_empty;
    assign fifo_rd_en = m_wvalid && m_wready;
    assign m_wlast    = in_data && (beat == LAST_BEAT);
    assign m_wdata    = fifo_dout;
    assign m_wstrb    = '1;

    assign m_awlen     = 8'(BURST_LEN - 1);
    assign m_awsize    = SIZE_32B;
    assign m_awburst   = BURST_INCR;
    assign m_awvalid   = aw_valid_q;
    assign m_bready    = b_ready_q;
    assign busy        = (state != ST_IDLE);
    assign wr_err      = err_q;
    assign bursts_done = done_q;

    // Burst sequencer: IDLE -> ADDR -> DATA -> RESP -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat       <= '0;
            aw_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ADDR;
                        aw_valid_q <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (m_awready) begin
                        state      <= ST_DATA;
                        aw_valid_q <= 1'b0;
                        beat       <= '0;
                    end
                end
                ST_DATA: begin
                    if (fifo_rd_en) begin
                        if (beat == LAST_BEAT) begin
                            state     <= ST_RESP;
                            b_ready_q <= 1'b1;
                            beat      <= '0;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (m_bvalid) begin
                        state     <= ST_IDLE;
                        b_ready_q <= 1'b0;
                        done_q    <= done_q + 32'd1;
                        if (m_bresp != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    burst_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STEP_BYTES   (STEP_BYTES),
        .BASE_ADDR    (BASE_ADDR),
        .REGION_BYTES (REGION_BYTES)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .addr    (m_awaddr)
    );

endmodule
